// File: rtl/fsm_seq_detect.sv
// Programmable serial sequence detector: runtime pattern of 1..MAXLEN bits,
// per-bit don't-care mask, overlapping/non-overlapping mode, saturating match counter.
module fsm_seq_detect #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [MAXLEN-1:0] pat_in,
  input  logic [MAXLEN-1:0] mask_in,
  input  logic [LW-1:0]     len_in,
  input  logic              ovl_in,
  input  logic              in_valid,
  input  logic              in,
  output logic              match,
  output logic [CNTW-1:0]   match_cnt,
  output logic [1:0]        state,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] sr_q, sr_d;
  logic [LW-1:0]     fill_q, fill_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [MAXLEN-1:0] mask_q, mask_d;
  logic [LW-1:0]     len_q, len_d;
  logic              ovl_q, ovl_d;
  logic              match_q, match_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              cfg_err_q, cfg_err_d;

  logic [MAXLEN-1:0] sr_shift;
  logic [LW-1:0]     fill_inc;
  logic              hit;
  logic              len_ok;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
    cfg_err_d = cfg_err_q;

    sr_shift = {sr_q[MAXLEN-2:0], in};
    fill_inc = (fill_q == len_q) ? len_q : fill_q + LW'(1);
    len_ok   = (len_in != '0) && (len_in <= LW'(MAXLEN));

    // Window compare on the post-shift register; bits at or above len are ignored.
    hit = 1'b1;
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      if ((LW'(i) < len_q) && mask_q[i] && (sr_shift[i] != pat_q[i])) begin
        hit = 1'b0;
      end
    end

    if (load) begin
      pat_d  = pat_in;
      mask_d = mask_in;
      len_d  = len_in;
      ovl_d  = ovl_in;
      sr_d   = '0;
      fill_d = '0;
      cnt_d  = '0;
      if (len_ok) begin
        state_d   = FILL;
        cfg_err_d = 1'b0;
      end else begin
        state_d   = IDLE;
        cfg_err_d = 1'b1;
      end
    end else if ((state_q != IDLE) && in_valid) begin
      sr_d   = sr_shift;
      fill_d = fill_inc;
      if (fill_inc == len_q) begin
        state_d = DETECT;
        if (hit) begin
          match_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNTW'(1);
          end
          // Non-overlap: the fill counter alone gates the next compare.
          if (!ovl_q) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      mask_q    <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Directed vector bench for fsm_seq_detect (MAXLEN=8, CNTW=8).
module tb_fsm_seq_detect;

  logic       clk = 1'b0;
  logic       clr, load, ovl_in, in_valid, in_bit;
  logic [7:0] pat_in, mask_in;
  logic [3:0] len_in;
  logic       match, cfg_err;
  logic [7:0] match_cnt;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fsm_seq_detect #(.MAXLEN(8), .CNTW(8)) dut (
    .clk(clk), .clr(clr), .load(load), .pat_in(pat_in), .mask_in(mask_in),
    .len_in(len_in), .ovl_in(ovl_in), .in_valid(in_valid), .in(in_bit),
    .match(match), .match_cnt(match_cnt), .state(state), .cfg_err(cfg_err)
  );

  typedef struct {
    string      name;
    logic       clr, load;
    logic [7:0] pat, mask;
    logic [3:0] len;
    logic       ovl, iv, b;
    logic       em;
    logic [7:0] ecnt;
    logic [1:0] est;
    logic       eerr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic c, logic l, logic [7:0] p, logic [7:0] m,
                              logic [3:0] len, logic o, logic iv, logic b,
                              logic em, logic [7:0] ecnt, logic [1:0] est, logic eerr);
    vec_t v;
    v.name = name; v.clr = c; v.load = l; v.pat = p; v.mask = m; v.len = len;
    v.ovl = o; v.iv = iv; v.b = b; v.em = em; v.ecnt = ecnt; v.est = est; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    clr = v.clr; load = v.load; pat_in = v.pat; mask_in = v.mask; len_in = v.len;
    ovl_in = v.ovl; in_valid = v.iv; in_bit = v.b;
    @(posedge clk);
    #1;
    check({v.name, ".match"},   32'(match),     32'(v.em));
    check({v.name, ".cnt"},     32'(match_cnt), 32'(v.ecnt));
    check({v.name, ".state"},   32'(state),     32'(v.est));
    check({v.name, ".cfg_err"}, 32'(cfg_err),   32'(v.eerr));
  endtask

  // Plain data bit with configuration inputs parked at zero.
  function automatic vec_t bit_v(string n, logic iv, logic b, logic em, logic [7:0] c,
                                 logic [1:0] s, logic e);
    return mk(n, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, iv, b, em, c, s, e);
  endfunction

  initial begin
    clr = 1'b0; load = 1'b0; pat_in = '0; mask_in = '0; len_in = '0;
    ovl_in = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

    vq.push_back(mk("reset", 0, 0, 8'h00, 8'h00, 4'd0, 0, 0, 0, 0, 8'd0, 2'd0, 0));
    vq.push_back(bit_v("idle_ignore", 1, 1, 0, 8'd0, 2'd0, 0));
    // overlap: 101 on 1,0,1,0,1
    vq.push_back(mk("ovl_load", 1, 1, 8'h05, 8'h07, 4'd3, 1, 0, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("ovl_b1", 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("ovl_b2", 1, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("ovl_b3", 1, 1, 1, 8'd1, 2'd2, 0));
    vq.push_back(bit_v("ovl_b4", 1, 0, 0, 8'd1, 2'd2, 0));
    vq.push_back(bit_v("ovl_b5", 1, 1, 1, 8'd2, 2'd2, 0));
    // non-overlap, load cycle carries a valid bit that must be discarded
    vq.push_back(mk("novl_load", 1, 1, 8'h05, 8'h07, 4'd3, 0, 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("novl_b1", 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("novl_b2", 1, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("novl_b3", 1, 1, 1, 8'd1, 2'd1, 0));
    vq.push_back(bit_v("novl_b4", 1, 0, 0, 8'd1, 2'd1, 0));
    vq.push_back(bit_v("novl_b5", 1, 1, 0, 8'd1, 2'd1, 0));
    vq.push_back(bit_v("novl_b6", 1, 0, 0, 8'd1, 2'd2, 0));
    // don't-care mask with in_valid gaps
    vq.push_back(mk("mask_load", 1, 1, 8'h09, 8'h09, 4'd4, 1, 0, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("mask_b1", 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("mask_b2", 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("mask_gap1", 0, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("mask_gap2", 0, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("mask_b3", 1, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("mask_b4", 1, 1, 1, 8'd1, 2'd2, 0));
    vq.push_back(bit_v("mask_b5", 1, 1, 1, 8'd2, 2'd2, 0));
    // invalid lengths
    vq.push_back(mk("len0_load", 1, 1, 8'h05, 8'h07, 4'd0, 1, 0, 0, 0, 8'd0, 2'd0, 1));
    vq.push_back(bit_v("len0_b1", 1, 1, 0, 8'd0, 2'd0, 1));
    vq.push_back(bit_v("len0_b2", 1, 1, 0, 8'd0, 2'd0, 1));
    vq.push_back(mk("len9_load", 1, 1, 8'h05, 8'h07, 4'd9, 1, 0, 0, 0, 8'd0, 2'd0, 1));
    vq.push_back(bit_v("len9_b1", 1, 1, 0, 8'd0, 2'd0, 1));
    vq.push_back(bit_v("len9_b2", 1, 0, 0, 8'd0, 2'd0, 1));
    vq.push_back(bit_v("len9_b3", 1, 1, 0, 8'd0, 2'd0, 1));
    vq.push_back(mk("len3_load", 1, 1, 8'h05, 8'h07, 4'd3, 1, 0, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("len3_b1", 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("len3_b2", 1, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("len3_b3", 1, 1, 1, 8'd1, 2'd2, 0));
    vq.push_back(bit_v("len3_b4", 1, 0, 0, 8'd1, 2'd2, 0));
    // clr with a completing bit in DETECT
    vq.push_back(mk("clr_hit", 0, 0, 8'h00, 8'h00, 4'd0, 0, 1, 1, 0, 8'd0, 2'd0, 0));
    vq.push_back(bit_v("post_clr_b1", 1, 1, 0, 8'd0, 2'd0, 0));
    vq.push_back(bit_v("post_clr_b2", 1, 0, 0, 8'd0, 2'd0, 0));
    vq.push_back(bit_v("post_clr_b3", 1, 1, 0, 8'd0, 2'd0, 0));
    // load beats in_valid: the bit in the load cycle must not count
    vq.push_back(mk("lp_load", 1, 1, 8'h03, 8'h03, 4'd2, 1, 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("lp_b1", 1, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("lp_b2", 1, 1, 1, 8'd1, 2'd2, 0));
    vq.push_back(bit_v("lp_b3", 1, 1, 1, 8'd2, 2'd2, 0));
    vq.push_back(mk("reload_det", 1, 1, 8'h03, 8'h03, 4'd2, 1, 0, 0, 0, 8'd0, 2'd1, 0));
    vq.push_back(bit_v("hold_nv", 0, 1, 0, 8'd0, 2'd1, 0));
    vq.push_back(mk("clr_over_load", 0, 1, 8'h05, 8'h07, 4'd3, 1, 1, 1, 0, 8'd0, 2'd0, 0));

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Saturation: len=1 pattern '1', 300 back-to-back ones.
    clr = 1'b1; load = 1'b1; pat_in = 8'h01; mask_in = 8'h01; len_in = 4'd1; ovl_in = 1'b1;
    in_valid = 1'b0; in_bit = 1'b0;
    @(posedge clk); #1;
    check("sat_load.state", 32'(state), 32'd1);
    load = 1'b0; pat_in = '0; mask_in = '0; len_in = '0; ovl_in = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      check("sat.match", 32'(match), 32'd1);
      check("sat.cnt", 32'(match_cnt), (k < 255) ? 32'(k) : 32'd255);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("sat_gap.match", 32'(match), 32'd0);
    check("sat_gap.cnt", 32'(match_cnt), 32'd255);
    check("sat_gap.state", 32'(state), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq_detect.md
# fsm_seq_detect

Programmable serial sequence detector. It generalises the fixed-length shift-and-compare detector to a runtime-loaded pattern of 1..MAXLEN bits. It adds a per-bit don't-care mask, overlapping or non-overlapping match mode, an input qualifier and a saturating match counter. It sits on a serial bit stream next to the other FSM blocks and flags each occurrence of the configured sequence.

## Interface
- MAXLEN, 8, maximum pattern length in bits (≥2)
- CNTW, 8, width of the match counter
- LW, $clog2(MAXLEN+1), width of the length field (derived, not overridden)

- clk  input  1  rising-edge clock
- clr  input  1  reset; synchronous, active-low
- load  input  1  capture configuration this cycle
- pat_in  input  MAXLEN  pattern; pat[len-1] is the first bit received, pat[0] the last
- mask_in  input  MAXLEN  1 = compare bit i, 0 = don't care
- len_in  input  LW  pattern length; valid range 1..MAXLEN
- ovl_in  input  1  1 = overlapping matches, 0 = non-overlapping
- in_valid  input  1  qualifies `in`
- in  input  1  serial data bit
- match  output  1  one-cycle registered match pulse
- match_cnt  output  CNTW  matches since last load/reset, saturating
- state  output  2  0 = IDLE, 1 = FILL, 2 = DETECT
- cfg_err  output  1  last load had an invalid length

## Operation
- Reset (clr=0 at posedge) clears everything:
  - outputs: match=0, match_cnt=0, state=IDLE, cfg_err=0
  - internal: shift register, fill counter, pat, mask, len and ovl are all cleared to 0.
  - clr has priority over every other input.
- Load (load=1, any state):
  - Capture pat_in, mask_in, len_in and ovl_in.
  - Clear the shift register, fill counter and match_cnt; match=0.
  - If len_in is in 1..MAXLEN: go to FILL and set cfg_err=0.
  - Otherwise: go to IDLE and set cfg_err=1.
  - load has priority over in_valid; a bit presented in the load cycle is discarded.
- IDLE: in and in_valid are ignored. The block leaves IDLE only on a valid load.
- Shift (FILL or DETECT with in_valid=1):
  - sr_next = {sr[MAXLEN-2:0], in}; the newest bit lands in sr[0].
  - The fill counter increments, saturating at len.
- Compare, evaluated on sr_next whenever fill_next == len:
  - hit = AND over i<len of (!mask[i] | (sr_next[i] == pat[i])).
  - Bits i ≥ len are ignored.
  - An all-zero mask matches every full window.
- FILL → DETECT when fill_next == len.
  - The compare is also evaluated on that completing bit, so a match is possible on the first full window.
- On hit:
  - match=1 for one cycle; match_cnt increments, saturating at 2^CNTW-1.
  - Overlap mode: stay in DETECT; the next bit can complete another match.
  - Non-overlap mode: clear the fill counter and go to FILL, so len fresh bits are required before the next match. The shift register is not cleared; the counter gates the compare.
- in_valid=0: no shift, no compare, match=0, state holds.
- Compatibility: MAXLEN=6, len=6, mask=6'h3F, ovl=1 reproduces the previous fixed 6-bit detector.

## Timing
- Configuration takes effect on the cycle after load. The first counted bit is the first in_valid cycle after the load cycle.
- match is registered. It is high in the cycle after the posedge that samples the completing bit, i.e. it rises on the same edge that shifts that bit in.
- match_cnt updates on the same edge as match.
- Throughput: one bit per cycle, no bubbles. Back-to-back matches are possible in overlap mode, including every cycle when len=1.
- Reset mid-operation: outputs take their reset values on the edge where clr=0 is sampled. The block stays in IDLE until a load.

## Test plan
- Overlap detection:
  - Load pat=3'b101, len=3, mask=3'b111, ovl=1.
  - Drive bits 1,0,1,0,1 on consecutive cycles.
  - Expect match after the 3rd and 5th bits and match_cnt=2.
- Non-overlap detection:
  - Same pattern with ovl=0 and the same stream.
  - Expect a single match after the 3rd bit, match_cnt=1 and state=FILL after the match.
- Don't-care mask plus input gaps:
  - Load pat=4'b1001, mask=4'b1001, len=4.
  - Drive 1,1,0,1, inserting two in_valid=0 cycles between the 2nd and 3rd bits.
  - Expect exactly one match after the 4th valid bit and match=0 during the gap cycles.
- Saturation:
  - Load pat=1, len=1, mask=1, ovl=1.
  - Drive 300 consecutive valid 1s.
  - Expect match high every cycle and match_cnt to hold at 255 from the 255th bit onward.
- Invalid configuration:
  - Load len=0, then len=9 (MAXLEN=8).
  - Expect cfg_err=1, state=IDLE and no match on any stream.
  - A following load with len=3 clears cfg_err.
- Reset and load priority:
  - Assert clr=0 in DETECT with in_valid=1 and a matching bit. Expect match=0, match_cnt=0 and state=IDLE next cycle, with later bits ignored.
  - Assert load together with in_valid. Expect that bit to be discarded (fill counter 0).
